// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the unified memory port arbiter:
//   - arb_state_t : arbiter FSM state encoding
//   - AW_DEFAULT / DW_DEFAULT : default address and data widths
//   - REQ_IF / REQ_D : requester identifiers (fetch, data)
package mem_port_arbiter_pkg;

    localparam int AW_DEFAULT = 32;
    localparam int DW_DEFAULT = 32;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_D  = 1'b1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        ISSUE_D = 3'd2,
        WAIT_I  = 3'd3,
        WAIT_D  = 3'd4,
        DROP    = 3'd5
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// sat_counter
// Saturating incrementer. The count sticks at all-ones instead of wrapping.
// Ports:
//   clk    : clock
//   reset  : synchronous, active-low; clears the count
//   inc    : increment enable for this cycle
//   count  : current count
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one req/gnt/rvalid memory port between instruction fetch (IF) and
// the Memory stage (D). One transaction is outstanding at a time; D wins a
// simultaneous request. Fetch responses killed by a taken branch are dropped.
//
// Handshakes:
//   if_req / d_req are levels held by the requester until the matching
//   x_valid pulse; x_valid is a one-cycle pulse in the cycle mem_rvalid
//   arrives. Downstream, mem_req rises with stable fields and is held until
//   the cycle mem_gnt is seen; exactly one mem_rvalid follows each grant.
//
// Ports:
//   clk, reset                    : clock, synchronous active-low reset
//   if_req, if_addr, if_flush     : fetch request and branch kill
//   if_rdata, if_valid            : fetch response
//   d_req, d_we, d_addr, d_wdata, d_be : data request
//   d_rdata, d_valid              : load data / store acknowledge
//   stall_if, stall_d             : requester is waiting
//   mem_req..mem_be, mem_gnt      : downstream request channel
//   mem_rvalid, mem_rdata         : downstream response channel
//   perf_conflict, perf_wait      : performance counters
//   dbg_state                     : current FSM state
//
// Configuration: define MEMARB_PERF_CNT_EN to build the performance counters;
// otherwise perf_conflict and perf_wait read as zero.
import mem_port_arbiter_pkg::*;

module mem_port_arbiter #(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            if_req,
    input  logic [AW-1:0]   if_addr,
    input  logic            if_flush,
    output logic [DW-1:0]   if_rdata,
    output logic            if_valid,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic [DW-1:0]   d_rdata,
    output logic            d_valid,

    output logic            stall_if,
    output logic            stall_d,

    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [DW-1:0]   mem_rdata,

    output logic [31:0]     perf_conflict,
    output logic [31:0]     perf_wait,

    output arb_state_t      dbg_state
);

    arb_state_t    state;
    logic          flush_pend;   // flush seen while the fetch awaits its grant
    logic [DW-1:0] if_rdata_q;
    logic [DW-1:0] d_rdata_q;

    // Responses are forwarded in the same cycle as mem_rvalid. A flush that
    // coincides with the fetch response suppresses it.
    assign if_valid = (state == WAIT_I) && mem_rvalid && !if_flush;
    assign d_valid  = (state == WAIT_D) && mem_rvalid;

    // Data passes straight through on the valid cycle, then the held copy
    // keeps the last delivered value visible.
    assign if_rdata = if_valid ? mem_rdata : if_rdata_q;
    assign d_rdata  = d_valid  ? mem_rdata : d_rdata_q;

    assign stall_if = if_req && !if_valid;
    assign stall_d  = d_req  && !d_valid;

    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_be     <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            if (if_valid) if_rdata_q <= mem_rdata;
            if (d_valid)  d_rdata_q  <= mem_rdata;

            case (state)
                IDLE: begin
                    flush_pend <= 1'b0;
                    if (d_req) begin
                        mem_req   <= 1'b1;
                        mem_we    <= d_we;
                        mem_addr  <= d_addr;
                        mem_wdata <= d_wdata;
                        mem_be    <= d_be;
                        state     <= ISSUE_D;
                    end else if (if_req) begin
                        // Fetches are always full-word reads.
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_addr  <= if_addr;
                        mem_wdata <= '0;
                        mem_be    <= '1;
                        state     <= ISSUE_I;
                    end
                end

                ISSUE_I: begin
                    // The request cannot be withdrawn once presented, so a
                    // flush is remembered and the response dropped later.
                    if (mem_gnt) begin
                        mem_req    <= 1'b0;
                        flush_pend <= 1'b0;
                        state      <= (flush_pend || if_flush) ? DROP : WAIT_I;
                    end else if (if_flush) begin
                        flush_pend <= 1'b1;
                    end
                end

                ISSUE_D: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT_D;
                    end
                end

                WAIT_I: begin
                    if (mem_rvalid) begin
                        state <= IDLE;
                    end else if (if_flush) begin
                        state <= DROP;
                    end
                end

                WAIT_D: begin
                    if (mem_rvalid) state <= IDLE;
                end

                DROP: begin
                    if (mem_rvalid) state <= IDLE;
                end

                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEMARB_PERF_CNT_EN
    logic conflict_inc;
    logic wait_inc;

    assign conflict_inc = (state == IDLE) && if_req && d_req;
    assign wait_inc     = stall_if || stall_d;

    sat_counter #(.W(32)) u_conflict_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (conflict_inc),
        .count (perf_conflict)
    );

    sat_counter #(.W(32)) u_wait_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (wait_inc),
        .count (perf_wait)
    );
`else
    assign perf_conflict = '0;
    assign perf_wait     = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are sampled on the falling edge.
import mem_port_arbiter_pkg::*;

module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_flush, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic [3:0]  d_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
    logic        if_valid, d_valid, stall_if, stall_d, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] perf_conflict, perf_wait;
    arb_state_t  dbg_state;

    int n_total = 0;
    int n_pass  = 0;

`ifdef MEMARB_PERF_CNT_EN
    localparam logic [31:0] EXP_CONFLICT = 32'd1;
    localparam logic [31:0] EXP_WAIT     = 32'd2;
`else
    localparam logic [31:0] EXP_CONFLICT = 32'd0;
    localparam logic [31:0] EXP_WAIT     = 32'd0;
`endif

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .stall_if(stall_if), .stall_d(stall_d),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .perf_conflict(perf_conflict), .perf_wait(perf_wait),
        .dbg_state(dbg_state)
    );

    // Advance to just after the next rising edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if_req = 0; if_flush = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_be = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        n_total++; if (dbg_state !== IDLE) $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req got=%b exp=0", mem_req); else n_pass++;
        n_total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); else n_pass++;
        n_total++; if (mem_be !== 4'h0) $display("FAIL reset_mem_be got=%h exp=0", mem_be); else n_pass++;
        n_total++; if (perf_wait !== 32'h0) $display("FAIL reset_perf_wait got=%0d exp=0", perf_wait); else n_pass++;
        reset = 1;
        next_cycle();
    endtask

    task automatic test_fetch();
        // cycle 0: request seen in IDLE
        if_req = 1; if_addr = 32'h100;
        @(negedge clk);
        n_total++; if (stall_if !== 1'b1) $display("FAIL fetch_stall_c0 got=%b exp=1", stall_if); else n_pass++;
        n_total++; if (mem_req !== 1'b0) $display("FAIL fetch_mem_req_c0 got=%b exp=0", mem_req); else n_pass++;
        next_cycle();
        // cycle 1: issued, granted immediately
        mem_gnt = 1;
        @(negedge clk);
        n_total++; if (mem_req !== 1'b1) $display("FAIL fetch_mem_req_c1 got=%b exp=1", mem_req); else n_pass++;
        n_total++; if (mem_addr !== 32'h100) $display("FAIL fetch_mem_addr got=%h exp=100", mem_addr); else n_pass++;
        n_total++; if (mem_we !== 1'b0 || mem_be !== 4'hF) $display("FAIL fetch_we_be got=%b/%h exp=0/f", mem_we, mem_be); else n_pass++;
        n_total++; if (stall_if !== 1'b1) $display("FAIL fetch_stall_c1 got=%b exp=1", stall_if); else n_pass++;
        next_cycle();
        // cycle 2: response
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0013;
        @(negedge clk);
        n_total++; if (if_valid !== 1'b1) $display("FAIL fetch_valid got=%b exp=1", if_valid); else n_pass++;
        n_total++; if (if_rdata !== 32'h13) $display("FAIL fetch_rdata got=%h exp=00000013", if_rdata); else n_pass++;
        n_total++; if (stall_if !== 1'b0) $display("FAIL fetch_stall_c2 got=%b exp=0", stall_if); else n_pass++;
        next_cycle();
        // cycle 3: back in IDLE, data held
        if_req = 0; mem_rvalid = 0; mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_total++; if (dbg_state !== IDLE) $display("FAIL fetch_idle got=%0d exp=%0d", dbg_state, IDLE); else n_pass++;
        n_total++; if (if_valid !== 1'b0) $display("FAIL fetch_valid_c3 got=%b exp=0", if_valid); else n_pass++;
        n_total++; if (if_rdata !== 32'h13) $display("FAIL fetch_rdata_hold got=%h exp=00000013", if_rdata); else n_pass++;
        n_total++; if (perf_wait !== EXP_WAIT) $display("FAIL fetch_perf_wait got=%0d exp=%0d", perf_wait, EXP_WAIT); else n_pass++;
        next_cycle();
    endtask

    task automatic test_conflict();
        reset = 0;
        next_cycle();
        reset = 1;
        // cycle 0: both request
        if_req = 1; if_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000; d_be = 4'hF;
        next_cycle();
        // cycle 1: D issued first
        mem_gnt = 1;
        @(negedge clk);
        n_total++; if (dbg_state !== ISSUE_D) $display("FAIL conf_state_c1 got=%0d exp=%0d", dbg_state, ISSUE_D); else n_pass++;
        n_total++; if (mem_addr !== 32'h2000) $display("FAIL conf_d_addr got=%h exp=2000", mem_addr); else n_pass++;
        n_total++; if (stall_if !== 1'b1 || stall_d !== 1'b1) $display("FAIL conf_stalls got=%b%b exp=11", stall_if, stall_d); else n_pass++;
        next_cycle();
        // cycle 2: load response
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'hCAFE_0001;
        @(negedge clk);
        n_total++; if (d_valid !== 1'b1 || if_valid !== 1'b0) $display("FAIL conf_d_valid got=%b/%b exp=1/0", d_valid, if_valid); else n_pass++;
        n_total++; if (d_rdata !== 32'hCAFE_0001) $display("FAIL conf_d_rdata got=%h exp=cafe0001", d_rdata); else n_pass++;
        next_cycle();
        // cycle 3: IDLE gap
        d_req = 0; mem_rvalid = 0;
        @(negedge clk);
        n_total++; if (dbg_state !== IDLE || mem_req !== 1'b0) $display("FAIL conf_gap got=%0d/%b exp=%0d/0", dbg_state, mem_req, IDLE); else n_pass++;
        next_cycle();
        // cycle 4: IF issued
        mem_gnt = 1;
        @(negedge clk);
        n_total++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) $display("FAIL conf_if_issue got=%b/%h exp=1/104", mem_req, mem_addr); else n_pass++;
        n_total++; if (perf_conflict !== EXP_CONFLICT) $display("FAIL conf_perf got=%0d exp=%0d", perf_conflict, EXP_CONFLICT); else n_pass++;
        next_cycle();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0040_0093;
        @(negedge clk);
        n_total++; if (if_valid !== 1'b1 || if_rdata !== 32'h0040_0093) $display("FAIL conf_if_resp got=%b/%h exp=1/00400093", if_valid, if_rdata); else n_pass++;
        next_cycle();
        if_req = 0; mem_rvalid = 0;
        next_cycle();
    endtask

    task automatic test_store();
        d_req = 1; d_we = 1; d_be = 4'b0011; d_wdata = 32'hDEAD_BEEF; d_addr = 32'h3000;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_total++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h3000)
                $display("FAIL store_hold_%0d got=%b/%b/%b/%h/%h exp=1/1/0011/deadbeef/3000", i, mem_req, mem_we, mem_be, mem_wdata, mem_addr);
            else n_pass++;
            n_total++; if (d_valid !== 1'b0 || stall_d !== 1'b1) $display("FAIL store_wait_%0d got=%b/%b exp=0/1", i, d_valid, stall_d); else n_pass++;
            next_cycle();
        end
        mem_gnt = 1;
        next_cycle();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0;
        @(negedge clk);
        n_total++; if (d_valid !== 1'b1 || mem_req !== 1'b0) $display("FAIL store_ack got=%b/%b exp=1/0", d_valid, mem_req); else n_pass++;
        next_cycle();
        d_req = 0; d_we = 0; mem_rvalid = 0;
        next_cycle();
    endtask

    task automatic test_flush_wait();
        if_req = 1; if_addr = 32'h200;
        next_cycle();
        mem_gnt = 1;
        next_cycle();
        // WAIT_I: taken branch, no response yet
        mem_gnt = 0; if_flush = 1;
        @(negedge clk);
        n_total++; if (if_valid !== 1'b0) $display("FAIL flushw_valid_c2 got=%b exp=0", if_valid); else n_pass++;
        next_cycle();
        if_flush = 0; if_addr = 32'h300;
        @(negedge clk);
        n_total++; if (dbg_state !== DROP) $display("FAIL flushw_drop got=%0d exp=%0d", dbg_state, DROP); else n_pass++;
        next_cycle();
        mem_rvalid = 1; mem_rdata = 32'h0000_0BAD;
        @(negedge clk);
        n_total++; if (if_valid !== 1'b0) $display("FAIL flushw_stale got=%b exp=0", if_valid); else n_pass++;
        next_cycle();
        mem_rvalid = 0;
        @(negedge clk);
        n_total++; if (dbg_state !== IDLE) $display("FAIL flushw_idle got=%0d exp=%0d", dbg_state, IDLE); else n_pass++;
        next_cycle();
        mem_gnt = 1;
        @(negedge clk);
        n_total++; if (mem_req !== 1'b1 || mem_addr !== 32'h300) $display("FAIL flushw_reissue got=%b/%h exp=1/300", mem_req, mem_addr); else n_pass++;
        next_cycle();
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h0000_0011;
        @(negedge clk);
        n_total++; if (if_valid !== 1'b1 || if_rdata !== 32'h11) $display("FAIL flushw_new_resp got=%b/%h exp=1/11", if_valid, if_rdata); else n_pass++;
        next_cycle();
        if_req = 0; mem_rvalid = 0;
        next_cycle();
    endtask

    task automatic test_flush_same_cycle();
        if_req = 1; if_addr = 32'h400;
        next_cycle();
        mem_gnt = 1;
        next_cycle();
        mem_gnt = 0; mem_rvalid = 1; if_flush = 1; mem_rdata = 32'h0000_BAD2;
        @(negedge clk);
        n_total++; if (if_valid !== 1'b0) $display("FAIL flushs_valid got=%b exp=0", if_valid); else n_pass++;
        n_total++; if (if_rdata !== 32'h11) $display("FAIL flushs_rdata got=%h exp=11", if_rdata); else n_pass++;
        next_cycle();
        mem_rvalid = 0; if_flush = 0; if_req = 0;
        @(negedge clk);
        n_total++; if (dbg_state !== IDLE) $display("FAIL flushs_idle got=%0d exp=%0d", dbg_state, IDLE); else n_pass++;
        next_cycle();
    endtask

    task automatic test_flush_issue();
        if_req = 1; if_addr = 32'h500;
        next_cycle();
        if_flush = 1;
        @(negedge clk);
        n_total++; if (mem_req !== 1'b1) $display("FAIL flushi_req_c1 got=%b exp=1", mem_req); else n_pass++;
        next_cycle();
        if_flush = 0;
        @(negedge clk);
        n_total++; if (mem_req !== 1'b1 || dbg_state !== ISSUE_I) $display("FAIL flushi_hold got=%b/%0d exp=1/%0d", mem_req, dbg_state, ISSUE_I); else n_pass++;
        next_cycle();
        mem_gnt = 1;
        next_cycle();
        mem_gnt = 0; if_req = 0;
        @(negedge clk);
        n_total++; if (dbg_state !== DROP || mem_req !== 1'b0) $display("FAIL flushi_drop got=%0d/%b exp=%0d/0", dbg_state, mem_req, DROP); else n_pass++;
        next_cycle();
        mem_rvalid = 1; mem_rdata = 32'h0000_BAD3;
        @(negedge clk);
        n_total++; if (if_valid !== 1'b0) $display("FAIL flushi_stale got=%b exp=0", if_valid); else n_pass++;
        next_cycle();
        mem_rvalid = 0;
        @(negedge clk);
        n_total++; if (dbg_state !== IDLE) $display("FAIL flushi_idle got=%0d exp=%0d", dbg_state, IDLE); else n_pass++;
        next_cycle();
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_we = 0; d_addr = 32'h600; d_be = 4'hF;
        next_cycle();
        mem_gnt = 1;
        next_cycle();
        mem_gnt = 0; reset = 0; d_req = 0;
        @(negedge clk);
        n_total++; if (dbg_state !== WAIT_D) $display("FAIL rstmid_pre got=%0d exp=%0d", dbg_state, WAIT_D); else n_pass++;
        next_cycle();
        reset = 1;
        @(negedge clk);
        n_total++; if (dbg_state !== IDLE) $display("FAIL rstmid_state got=%0d exp=%0d", dbg_state, IDLE); else n_pass++;
        n_total++; if (mem_req !== 1'b0 || d_valid !== 1'b0) $display("FAIL rstmid_req_valid got=%b/%b exp=0/0", mem_req, d_valid); else n_pass++;
        n_total++; if (mem_addr !== 32'h0) $display("FAIL rstmid_addr got=%h exp=0", mem_addr); else n_pass++;
        n_total++; if (perf_conflict !== 32'h0 || perf_wait !== 32'h0) $display("FAIL rstmid_perf got=%0d/%0d exp=0/0", perf_conflict, perf_wait); else n_pass++;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_conflict();
        test_store();
        test_flush_wait();
        test_flush_same_cycle();
        test_flush_issue();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-requester arbiter that shares the pipelined RISC-V core's single unified memory port between instruction fetch (IF) and the Memory stage (D). It sequences one transaction at a time onto a req/gnt/rvalid memory interface, returns data to the winning requester and raises per-requester stall outputs that the hazard unit ORs into its stall terms. IF responses made stale by a taken branch are discarded.

## Interface
- AW, 32, address width
- DW, 32, data width; byte enables DW/8
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- if_req, if_addr[AW]  in  fetch request, held until if_valid
- if_flush  in  1  taken branch (PcSrcE); kills outstanding fetch
- if_rdata[DW], if_valid  out  fetch data, 1-cycle valid pulse
- d_req, d_we, d_addr[AW], d_wdata[DW], d_be[DW/8]  in  data request, held until d_valid
- d_rdata[DW], d_valid  out  load data / store ack, 1-cycle pulse
- stall_if, stall_d  out  1  requester waiting
- mem_req, mem_we, mem_addr, mem_wdata, mem_be  out  downstream request, registered
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid, mem_rdata[DW]  in  exactly one response per granted request, loads and stores
- perf_conflict[32], perf_wait[32]  out  performance counters

## Operation
- FSM: IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D, DROP.
- IDLE: d_req wins over if_req (older instruction). Winner's fields latched into mem_* registers; next state ISSUE_D/ISSUE_I. IF writes forced mem_we=0, mem_be all ones.
- ISSUE_x: mem_req=1, fields stable until mem_gnt; on gnt go WAIT_x. mem_req never withdrawn before gnt.
- WAIT_x: on mem_rvalid pulse x_valid, pass mem_rdata to x_rdata, return IDLE.
- Requests arriving while busy wait in IDLE arbitration; no queueing, one outstanding transaction.
- if_flush in ISSUE_I: stay until gnt, then DROP. In WAIT_I: go DROP. Same cycle as mem_rvalid in WAIT_I: data discarded, if_valid stays 0. DROP: on mem_rvalid go IDLE, no valid. if_flush in IDLE, ISSUE_D, WAIT_D: no effect.
- stall_if = if_req & ~if_valid; stall_d = d_req & ~d_valid. Both combinational.
- rdata outputs hold last value between pulses.

## Timing
- Reset: state IDLE, mem_req 0, mem_* fields 0, valids 0, counters 0.
- Min latency: request seen cycle 0, mem_req cycle 1, gnt cycle 1, rvalid cycle 2, x_valid cycle 2 (same cycle as rvalid); new arbitration cycle 3.
- Back-to-back: IDLE always occupies one cycle between transactions.
- Reset mid-transaction: abandoned, IDLE next cycle; memory reset concurrently.

## Configuration
- MEMARB_PERF_CNT_EN defined: perf_conflict increments each IDLE cycle with if_req & d_req; perf_wait increments each cycle stall_if | stall_d; both saturate at 0xFFFFFFFF.
- Undefined: counters not built, perf outputs tied 0.

## Structure
- Shared package: FSM state enum, AW/DW defaults, requester ID constants (REQ_IF, REQ_D).
- Sub-module: sat_counter (32-bit saturating incrementer, sync active-low reset), instantiated twice under macro.

## Test plan
- Fetch only: if_addr=0x100, gnt immediate, rvalid next cycle with 0x00000013 -> if_valid cycle 2, if_rdata=0x00000013, stall_if high cycles 0-1.
- Simultaneous if_req/d_req (load 0x2000) -> D issued first, d_valid then IF issued after one IDLE cycle; perf_conflict=1 with macro.
- Store: d_we=1, d_be=4'b0011, d_wdata=0xDEADBEEF -> mem_we=1, mem_be=0011 held until gnt delayed 3 cycles; d_valid on rvalid.
- Flush in WAIT_I with rvalid 2 cycles later -> if_valid never asserts; next if_req issues normally.
- Flush same cycle as mem_rvalid -> discarded; flush in ISSUE_I with gnt delayed 2 cycles -> mem_req held, response dropped.
- reset low in WAIT_D -> next cycle mem_req=0, d_valid=0, counters 0, state IDLE.
